// File: rtl/pixel_ray_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_ray_generator                                                      |
// | Raster-order ray emitter: camera origin, incremental direction, address. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pixel_ray_generator #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int FP_W   = 32,
  parameter int FRAC_W = 16,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [FP_W-1:0]   cam_x_i,
  input  logic [FP_W-1:0]   cam_y_i,
  input  logic [FP_W-1:0]   cam_z_i,
  input  logic [FP_W-1:0]   dir0_x_i,
  input  logic [FP_W-1:0]   dir0_y_i,
  input  logic [FP_W-1:0]   dir0_z_i,
  input  logic [FP_W-1:0]   du_x_i,
  input  logic [FP_W-1:0]   du_y_i,
  input  logic [FP_W-1:0]   du_z_i,
  input  logic [FP_W-1:0]   dv_x_i,
  input  logic [FP_W-1:0]   dv_y_i,
  input  logic [FP_W-1:0]   dv_z_i,
  input  logic              ray_ready_i,
  output logic              ray_valid_o,
  output logic [FP_W-1:0]   ray_org_x_o,
  output logic [FP_W-1:0]   ray_org_y_o,
  output logic [FP_W-1:0]   ray_org_z_o,
  output logic [FP_W-1:0]   ray_dir_x_o,
  output logic [FP_W-1:0]   ray_dir_y_o,
  output logic [FP_W-1:0]   ray_dir_z_o,
  output logic [ADDR_W-1:0] ray_addr_o,
  output logic              ray_last_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (FRAC_W >= FP_W || FRAC_W < 0 || H_RES < 2 || V_RES < 2) begin : g_bad_params
    $error("pixel_ray_generator: illegal parameter combination");
  end

  logic [1:0] state_q, state_d;

  logic [2:0][FP_W-1:0] cam_q, cam_d;
  logic [2:0][FP_W-1:0] dir_q, dir_d;
  logic [2:0][FP_W-1:0] row_q, row_d;
  logic [2:0][FP_W-1:0] du_q, du_d;
  logic [2:0][FP_W-1:0] dv_q, dv_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;

  logic w_start;
  logic w_beat;
  logic w_x_end;
  logic w_last_pix;

  assign w_start    = (state_q == S_IDLE) && start_i && !abort_i;
  assign w_beat     = (state_q == S_RUN) && ray_ready_i && !abort_i;
  assign w_x_end    = (x_q == X_MAX);
  assign w_last_pix = w_x_end && (y_q == Y_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_start) state_d = S_RUN;
      S_RUN: begin
        if (abort_i)                      state_d = S_IDLE;
        else if (w_beat && w_last_pix)    state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ray_valid_o  = (state_q == S_RUN);
    busy_o       = (state_q == S_RUN) || (state_q == S_DONE);
    frame_done_o = (state_q == S_DONE);
    ray_last_o   = (state_q == S_RUN) && w_last_pix;
  end

  // A row wrap restarts from the row base so the column steps never accumulate across rows.
  always_comb begin
    cam_d  = cam_q;
    dir_d  = dir_q;
    row_d  = row_q;
    du_d   = du_q;
    dv_d   = dv_q;
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (w_start) begin
      cam_d  = {cam_z_i, cam_y_i, cam_x_i};
      dir_d  = {dir0_z_i, dir0_y_i, dir0_x_i};
      row_d  = {dir0_z_i, dir0_y_i, dir0_x_i};
      du_d   = {du_z_i, du_y_i, du_x_i};
      dv_d   = {dv_z_i, dv_y_i, dv_x_i};
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (w_beat) begin
      addr_d = addr_q + ADDR_W'(1);
      if (!w_x_end) begin
        x_d = x_q + X_W'(1);
        for (int i = 0; i < 3; i++) begin
          dir_d[i] = dir_q[i] + du_q[i];
        end
      end else begin
        x_d = '0;
        y_d = y_q + Y_W'(1);
        for (int i = 0; i < 3; i++) begin
          row_d[i] = row_q[i] + dv_q[i];
          dir_d[i] = row_q[i] + dv_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cam_q  <= '0;
      dir_q  <= '0;
      row_q  <= '0;
      du_q   <= '0;
      dv_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      cam_q  <= cam_d;
      dir_q  <= dir_d;
      row_q  <= row_d;
      du_q   <= du_d;
      dv_q   <= dv_d;
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign ray_org_x_o = cam_q[0];
  assign ray_org_y_o = cam_q[1];
  assign ray_org_z_o = cam_q[2];
  assign ray_dir_x_o = dir_q[0];
  assign ray_dir_y_o = dir_q[1];
  assign ray_dir_z_o = dir_q[2];
  assign ray_addr_o  = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_ray_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_ray_generator                                                   |
// | Self-checking bench: vector table, corner sequences, randomized frames.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pixel_ray_generator;

  localparam int H = 4;
  localparam int V = 3;
  localparam int N = H * V;

  logic clk = 1'b0;
  logic rst;
  logic start, abort, ray_ready;
  logic [2:0][31:0] in_cam, in_dir0, in_du, in_dv;
  logic        ray_valid, ray_last, busy, frame_done;
  logic [31:0] org [3];
  logic [31:0] dir [3];
  logic [19:0] ray_addr;

  always #5 clk = ~clk;

  pixel_ray_generator #(.H_RES(H), .V_RES(V), .FP_W(32), .FRAC_W(16), .ADDR_W(20)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .cam_x_i(in_cam[0]), .cam_y_i(in_cam[1]), .cam_z_i(in_cam[2]),
    .dir0_x_i(in_dir0[0]), .dir0_y_i(in_dir0[1]), .dir0_z_i(in_dir0[2]),
    .du_x_i(in_du[0]), .du_y_i(in_du[1]), .du_z_i(in_du[2]),
    .dv_x_i(in_dv[0]), .dv_y_i(in_dv[1]), .dv_z_i(in_dv[2]),
    .ray_ready_i(ray_ready), .ray_valid_o(ray_valid),
    .ray_org_x_o(org[0]), .ray_org_y_o(org[1]), .ray_org_z_o(org[2]),
    .ray_dir_x_o(dir[0]), .ray_dir_y_o(dir[1]), .ray_dir_z_o(dir[2]),
    .ray_addr_o(ray_addr), .ray_last_o(ray_last), .busy_o(busy), .frame_done_o(frame_done)
  );

  typedef struct packed {
    logic [2:0][31:0] cam;
    logic [2:0][31:0] dir0;
    logic [2:0][31:0] du;
    logic [2:0][31:0] dv;
    logic [2:0][31:0] exp_last_dir;
  } vec_t;

  vec_t tab [3];

  int errors = 0;
  int checks = 0;

  logic [2:0][31:0] fr_cam, fr_dir0, fr_du, fr_dv;
  logic [31:0] last_dir [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: pixel k of the frame is dir0 + x*du + y*dv, wrapped to 32 bits.
  function automatic logic [31:0] model_dir(input int c, input int k);
    logic [31:0] xs, ys;
    xs = 32'(k % H);
    ys = 32'(k / H);
    return fr_dir0[c] + xs * fr_du[c] + ys * fr_dv[c];
  endfunction

  task automatic load_frame(input vec_t v);
    fr_cam  = v.cam;
    fr_dir0 = v.dir0;
    fr_du   = v.du;
    fr_dv   = v.dv;
  endtask

  // Called at a negedge; returns at the negedge where pixel 0 should be presented.
  task automatic do_start();
    in_cam  = fr_cam;
    in_dir0 = fr_dir0;
    in_du   = fr_du;
    in_dv   = fr_dv;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // mode 0: ready high; 1: 3-cycle stall at addr 5; 2: random ready; 3: ready high + stray start at addr 7
  task automatic run_frame(input int mode, input int exp_cycles);
    int k = 0;
    int cyc = 0;
    int stall = 0;
    bit injected = 0;
    bit prev_hold = 0;
    logic [31:0] h_dir [3];
    logic [19:0] h_addr;
    while (k < N && cyc < 200) begin
      chk("valid_in_frame", ray_valid, 1);
      if (prev_hold) begin
        for (int c = 0; c < 3; c++) chk($sformatf("hold_dir%0d", c), dir[c], h_dir[c]);
        chk("hold_addr", ray_addr, h_addr);
      end
      chk("addr", ray_addr, k);
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("dir%0d_k%0d", c, k), dir[c], model_dir(c, k));
        chk($sformatf("org%0d", c), org[c], fr_cam[c]);
      end
      chk("last", ray_last, (k == N - 1));
      if (k == N - 1) for (int c = 0; c < 3; c++) last_dir[c] = dir[c];
      case (mode)
        1: if (k == 5 && stall < 3) begin ray_ready = 1'b0; stall++; end else ray_ready = 1'b1;
        2: ray_ready = ($urandom_range(0, 99) < 70);
        default: ray_ready = 1'b1;
      endcase
      if (mode == 3 && k == 7 && !injected) begin
        injected = 1;
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
          in_cam[c] = $urandom; in_dir0[c] = $urandom; in_du[c] = $urandom; in_dv[c] = $urandom;
        end
      end
      prev_hold = ray_valid && !ray_ready;
      for (int c = 0; c < 3; c++) h_dir[c] = dir[c];
      h_addr = ray_addr;
      if (ray_valid && ray_ready) k++;
      cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    chk("frame_no_timeout", (cyc < 200), 1);
    if (exp_cycles >= 0) chk("frame_cycles", cyc, exp_cycles);
    chk("done_pulse", frame_done, 1);
    chk("done_busy", busy, 1);
    chk("done_valid", ray_valid, 0);
    @(negedge clk);
    chk("after_done_pulse", frame_done, 0);
    chk("after_done_busy", busy, 0);
  endtask

  initial begin
    tab[0] = '{cam: {32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
               dir0: {32'h0001_0000, 32'h0001_8000, 32'hFFFE_0000},
               du: {32'h0, 32'h0, 32'h0001_0000},
               dv: {32'h0, 32'hFFFF_0000, 32'h0},
               exp_last_dir: {32'h0001_0000, 32'hFFFF_8000, 32'h0001_0000}};
    tab[1] = '{cam: {32'h0, 32'h0, 32'h0},
               dir0: {32'h0, 32'h0, 32'h7FFF_0000},
               du: {32'h0, 32'h0, 32'h0001_0000},
               dv: {32'h0, 32'h0, 32'h0},
               exp_last_dir: {32'h0, 32'h0, 32'h8002_0000}};
    tab[2] = '{cam: {32'hFFFF_0000, 32'h1234_5678, 32'h0000_8000},
               dir0: {32'h0, 32'h0, 32'h0},
               du: {32'hFFFF_0000, 32'h0000_4000, 32'h0000_8000},
               dv: {32'h0002_0000, 32'h0001_0000, 32'h0},
               exp_last_dir: {32'h0001_0000, 32'h0002_C000, 32'h0001_8000}};

    rst = 1'b1; start = 1'b0; abort = 1'b0; ray_ready = 1'b0;
    in_cam = '0; in_dir0 = '0; in_du = '0; in_dv = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", ray_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_last", ray_last, 0);
    chk("rst_addr", ray_addr, 0);
    chk("rst_dir_x", dir[0], 0);
    chk("rst_org_z", org[2], 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      load_frame(tab[i]);
      do_start();
      run_frame(0, N);
      for (int c = 0; c < 3; c++) chk($sformatf("tab%0d_last_dir%0d", i, c), last_dir[c], tab[i].exp_last_dir[c]);
    end

    load_frame(tab[0]);
    do_start();
    run_frame(1, N + 3);

    do_start();
    run_frame(3, N);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_valid", ray_valid, 0);

    begin : abort_seq
      int n = 0;
      load_frame(tab[2]);
      ray_ready = 1'b1;
      do_start();
      while (!(ray_valid && ray_addr == 20'd6) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("abort_reach_addr6", (n < 20), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_valid", ray_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", frame_done, 0);
      repeat (2) begin
        @(negedge clk);
        chk("abort_no_done", frame_done, 0);
      end
      do_start();
      run_frame(0, N);
    end

    begin : rst_seq
      int n = 0;
      load_frame(tab[0]);
      ray_ready = 1'b1;
      do_start();
      while (!(ray_valid && ray_addr == 20'd4) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rst_reach_addr4", (n < 20), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", ray_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_addr", ray_addr, 0);
      chk("arst_dir_y", dir[1], 0);
      chk("arst_org_x", org[0], 0);
      @(negedge clk);
      rst = 1'b0;
      chk("arst_done", frame_done, 0);
      @(negedge clk);
      chk("arst_idle", busy, 0);
      do_start();
      run_frame(0, N);
    end

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        fr_cam[c] = $urandom; fr_dir0[c] = $urandom; fr_du[c] = $urandom; fr_dv[c] = $urandom;
      end
      do_start();
      run_frame(2, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
